// File: rtl/tv80_busctl.sv
// tv80_busctl: Z80 bus-cycle controller for the TV80 core.
// It produces registered mreq_n/iorq_n/rd_n/wr_n strobes from the core's one-hot
// machine-cycle and T-state outputs, and latches read data for the core.
// It also inserts per-cycle-type wait states, which are merged with ext_wait_n.
// Optional feature: define TV80_BUSCTL_REFRESH_EN to enable the M1 refresh strobe
// and the rfsh_addr row counter. When it is not defined, rfsh_addr is held at 0.
module tv80_busctl #(
   parameter int DW       = 8,
   parameter int T2WRITE  = 0,
   parameter int M1_WAIT  = 0,
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cen,
   input  logic [6:0]    mcycle,
   input  logic [6:0]    tstate,
   input  logic          intcycle_n,
   input  logic          no_read,
   input  logic          write,
   input  logic          iorq,
   input  logic          ext_wait_n,
   input  logic [DW-1:0] di,
   output logic          wait_core_n,
   output logic          mreq_n,
   output logic          iorq_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic [DW-1:0] di_reg,
   output logic [6:0]    rfsh_addr
);

   logic [2:0]    n_sel;
   logic          int_wait;
   logic          rq;
   logic          wr_cond;
   logic          busy_q, busy_d;
   logic [2:0]    wcnt_q, wcnt_d;
   logic          mreq_n_q, mreq_n_d;
   logic          iorq_n_q, iorq_n_d;
   logic          rd_n_q, rd_n_d;
   logic          wr_n_q, wr_n_d;
   logic [DW-1:0] di_reg_q, di_reg_d;
   logic [6:0]    rfsh_addr_q, rfsh_addr_d;
   logic          unused_inputs;

   // Upper cycle/state bits are not decoded here.
   assign unused_inputs = ^{mcycle[6:1], tstate[6:3], tstate[0]};

   // Select the wait-state count for the current cycle type
   always_comb begin
      if (mcycle[0]) begin
         n_sel = intcycle_n ? 3'(M1_WAIT) : 3'(IO_WAIT);
      end else if (iorq) begin
         n_sel = 3'(IO_WAIT);
      end else if (no_read && !write) begin
         n_sel = 3'd0;
      end else begin
         n_sel = 3'(MEM_WAIT);
      end
   end

   // Before busy is set, the first T2 clock uses n_sel directly so that wait has no latency.
   assign int_wait    = tstate[2] & (busy_q ? (wcnt_q != 3'd0) : (n_sel != 3'd0));
   assign wait_core_n = ext_wait_n & ~int_wait;
   assign rq          = tstate[1] | (tstate[2] & ~wait_core_n);
   assign wr_cond     = write & ((T2WRITE == 0) ? tstate[2] : rq);

   // Wait counter: load on entering T2, count down while held there, clear outside T2
   always_comb begin
      busy_d = busy_q;
      wcnt_d = wcnt_q;
      if (cen) begin
         if (tstate[2]) begin
            if (!busy_q) begin
               busy_d = 1'b1;
               wcnt_d = (n_sel == 3'd0) ? 3'd0 : n_sel - 3'd1;
            end else if (wcnt_q != 3'd0) begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end else begin
            busy_d = 1'b0;
            wcnt_d = 3'd0;
         end
      end
   end

   // Bus strobe decode; the decoded values are registered on every clk, independent of cen
   always_comb begin
      mreq_n_d = 1'b1;
      iorq_n_d = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      if (mcycle[0]) begin
         if (rq) begin
            rd_n_d   = ~intcycle_n;
            mreq_n_d = ~intcycle_n;
            iorq_n_d = intcycle_n;
         end
`ifdef TV80_BUSCTL_REFRESH_EN
         if (tstate[3]) begin
            mreq_n_d = 1'b0;
         end
`endif
      end else begin
         if (rq && !no_read && !write) begin
            rd_n_d   = 1'b0;
            iorq_n_d = ~iorq;
            mreq_n_d = iorq;
         end
         if (wr_cond) begin
            wr_n_d   = 1'b0;
            iorq_n_d = ~iorq;
            mreq_n_d = iorq;
         end
      end
   end

   // Capture read data on every T2 clock where the core is not being held
   always_comb begin
      di_reg_d = di_reg_q;
      if (tstate[2] && wait_core_n) begin
         di_reg_d = di;
      end
   end

   // Refresh row counter; it advances once per opcode-fetch T4
   always_comb begin
`ifdef TV80_BUSCTL_REFRESH_EN
      rfsh_addr_d = rfsh_addr_q;
      if (cen && mcycle[0] && tstate[4] && intcycle_n) begin
         rfsh_addr_d = rfsh_addr_q + 7'd1;
      end
`else
      rfsh_addr_d = 7'd0;
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q      <= 1'b0;
         wcnt_q      <= 3'd0;
         mreq_n_q    <= 1'b1;
         iorq_n_q    <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         di_reg_q    <= '0;
         rfsh_addr_q <= 7'd0;
      end else begin
         busy_q      <= busy_d;
         wcnt_q      <= wcnt_d;
         mreq_n_q    <= mreq_n_d;
         iorq_n_q    <= iorq_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         di_reg_q    <= di_reg_d;
         rfsh_addr_q <= rfsh_addr_d;
      end
   end

   assign mreq_n    = mreq_n_q;
   assign iorq_n    = iorq_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign di_reg    = di_reg_q;
   assign rfsh_addr = rfsh_addr_q;

endmodule
